window_gen: RTL and testbench

Streaming 3x3 window generator that produces the `window_valid` / `window_in` stream consumed by the convolution core. It accepts a raster-order pixel stream, one 8-bit pixel per cycle, and buffers the two previous image rows in internal line buffers. For every fully populated 3x3 neighbourhood (valid region only, no padding) it emits one packed 72-bit window with a one-cycle valid strobe.

---
 rtl/window_gen.sv | 101 ++++++++++
 tb/tb_window_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/window_gen.sv
// ============================================================================
// Module   : window_gen
// Purpose  : Streaming 3x3 window generator over a raster pixel stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        window_valid,
  output logic [71:0] window_out,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_two  = CW'(2);
  localparam logic [RW-1:0] c_row_two  = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_lb0 [IMG_W];
  logic [7:0]    r_lb1 [IMG_W];
  logic [71:0]   r_win;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_next;
  logic [RW-1:0] w_row_next;
  logic [7:0]    w_top;
  logic [7:0]    w_mid;
  logic [71:0]   w_win_next;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_emit;

  // frame_start retargets the current pixel to (0,0) before anything else looks at position
  always_comb begin
    w_col      = frame_start ? '0 : r_col;
    w_row      = frame_start ? '0 : r_row;
    w_last_col = (w_col == c_col_last);
    w_last_row = (w_row == c_row_last);
    w_emit     = (w_col >= c_col_two) && (w_row >= c_row_two);
    w_top      = r_lb1[w_col];
    w_mid      = r_lb0[w_col];
    w_win_next = {r_win[63:48], w_top, r_win[39:24], w_mid, r_win[15:0], pix_in};
    w_col_next = w_last_col ? '0 : w_col + CW'(1);
    w_row_next = w_row;
    if (w_last_col) begin
      w_row_next = w_last_row ? '0 : w_row + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      window_valid <= 1'b0;
      window_out   <= '0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (pix_valid) begin
        r_col      <= w_col_next;
        r_row      <= w_row_next;
        r_win      <= w_win_next;
        frame_done <= w_last_col && w_last_row;
        if (w_emit) begin
          window_valid <= 1'b1;
          window_out   <= w_win_next;
        end
      end else if (frame_start) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  // Line buffers carry no reset; row/col gating keeps stale data out of emitted windows
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= pix_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_gen.sv
// ============================================================================
// Module   : tb_window_gen
// Purpose  : Directed self-checking bench for window_gen on a 4x4 image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_gen;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        window_valid;
  logic [71:0] window_out;
  logic        frame_done;

  int vectors;
  int miscompares;
  int win_count;
  int fd_count;
  logic [71:0] exp_last;
  logic [71:0] exp_tab [4];

  window_gen #(.IMG_W(4), .IMG_H(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_in       (pix_in),
    .window_valid (window_valid),
    .window_out   (window_out),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_int(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs at negedge, check all outputs 1 time unit after posedge
  task automatic cycle(input logic r, input logic fs, input logic pv, input logic [7:0] px,
                       input logic exp_v, input logic [71:0] exp_w, input logic exp_fd,
                       input string tag);
    @(negedge clk);
    rst = r; frame_start = fs; pix_valid = pv; pix_in = px;
    @(posedge clk);
    #1;
    if (exp_v) exp_last = exp_w;
    if (window_valid === 1'b1) win_count++;
    if (frame_done === 1'b1) fd_count++;
    vectors++;
    assert (window_valid === exp_v) else begin
      miscompares++;
      $error("FAIL %s valid: observed %b expected %b", tag, window_valid, exp_v);
    end
    vectors++;
    assert (window_out === exp_last) else begin
      miscompares++;
      $error("FAIL %s window: observed %h expected %h", tag, window_out, exp_last);
    end
    vectors++;
    assert (frame_done === exp_fd) else begin
      miscompares++;
      $error("FAIL %s frame_done: observed %b expected %b", tag, frame_done, exp_fd);
    end
  endtask

  // Streams the first n_pix pixels of a 4x4 frame with value base+4r+c
  task automatic feed_frame(input logic [7:0] base, input int n_pix, input bit bubbles,
                            input bit fs_first, input string tag);
    for (int i = 0; i < n_pix; i++) begin
      int r;
      int c;
      logic ev;
      logic [71:0] ew;
      r = i / 4;
      c = i % 4;
      if (bubbles) begin
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int k = 0; k < idle; k++)
          cycle(1'b0, 1'b0, 1'b0, 8'hEE, 1'b0, 72'h0, 1'b0, {tag, "_idle"});
      end
      ev = (r >= 2) && (c >= 2);
      ew = ev ? (exp_tab[(r - 2) * 2 + (c - 2)] | {9{base}}) : 72'h0;
      cycle(1'b0, fs_first && (i == 0), 1'b1, base + 8'(4 * r + c),
            ev, ew, (i == 15), tag);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    win_count   = 0;
    fd_count    = 0;
    exp_last    = 72'h0;
    exp_tab[0]  = 72'h00_01_02_04_05_06_08_09_0A;
    exp_tab[1]  = 72'h01_02_03_05_06_07_09_0A_0B;
    exp_tab[2]  = 72'h04_05_06_08_09_0A_0C_0D_0E;
    exp_tab[3]  = 72'h05_06_07_09_0A_0B_0D_0E_0F;
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 72'h0, 1'b0, "reset0");
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 72'h0, 1'b0, "reset1");

    // First/last window, continuous stream
    win_count = 0; fd_count = 0;
    feed_frame(8'h00, 16, 1'b0, 1'b0, "cont");
    check_int("cont_windows", win_count, 4);
    check_int("cont_done", fd_count, 1);

    // Same frame with input bubbles
    win_count = 0; fd_count = 0;
    feed_frame(8'h00, 16, 1'b1, 1'b0, "bubble");
    check_int("bubble_windows", win_count, 4);

    // Back-to-back frames, different data
    win_count = 0; fd_count = 0;
    feed_frame(8'h80, 16, 1'b0, 1'b0, "b2b_f1");
    feed_frame(8'h00, 16, 1'b0, 1'b0, "b2b_f2");
    check_int("b2b_windows", win_count, 8);
    check_int("b2b_done", fd_count, 2);

    // frame_start with pix_valid abandons a partial frame
    win_count = 0; fd_count = 0;
    feed_frame(8'h40, 7, 1'b0, 1'b0, "fs_partial");
    feed_frame(8'h00, 16, 1'b0, 1'b1, "fs_restart");
    check_int("fs_windows", win_count, 4);
    check_int("fs_done", fd_count, 1);

    // frame_start during an idle cycle
    win_count = 0; fd_count = 0;
    feed_frame(8'h40, 5, 1'b0, 1'b0, "fsidle_partial");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 72'h0, 1'b0, "fsidle_idle");
    feed_frame(8'h00, 16, 1'b0, 1'b0, "fsidle_frame");
    check_int("fsidle_windows", win_count, 4);

    // Reset mid-frame overrides frame_start and pix_valid
    win_count = 0; fd_count = 0;
    feed_frame(8'h80, 9, 1'b0, 1'b0, "rst_partial");
    exp_last = 72'h0;
    cycle(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 72'h0, 1'b0, "rst_pulse");
    feed_frame(8'h00, 16, 1'b0, 1'b0, "rst_frame");
    check_int("rst_windows", win_count, 4);
    check_int("rst_done", fd_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
